// File: rtl/lane_stats_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lane_stats_pkg
// Brief    : Shared types and RGB565 field layout for the lane colour stats.
// Revision : 1.0  initial release
// ============================================================================
package lane_stats_pkg;

    localparam int LANE_CNT_W = 15;

    // RGB565 layout: R=[15:11], G=[10:5], B=[4:0]
    localparam int R_LSB = 11;
    localparam int R_W   = 5;
    localparam int G_LSB = 5;
    localparam int G_W   = 6;
    localparam int B_LSB = 0;
    localparam int B_W   = 5;

    typedef logic [LANE_CNT_W-1:0] lane_count_t;

    typedef enum logic [1:0] {
        SYNC    = 2'd0,
        ACCUM   = 2'd1,
        FLUSH   = 2'd2,
        PUBLISH = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rgb565_red_classifier.sv
`default_nettype none
// ============================================================================
// Module   : rgb565_red_classifier
// Brief    : Combinational red-pixel test, row-window check and lane select.
// Revision : 1.0  initial release
// ============================================================================
module rgb565_red_classifier
    import lane_stats_pkg::*;
#(
    parameter int IMG_W     = 320,
    parameter int NUM_LANES = 4,
    parameter int ROI_Y0    = 120,
    parameter int ROI_Y1    = 239,
    parameter int R_MIN     = 20,
    parameter int G_MAX     = 24,
    parameter int B_MAX     = 12
) (
    input  logic [9:0]  i_pix_x,
    input  logic [9:0]  i_pix_y,
    input  logic [15:0] i_pix_data,
    output logic        o_qualify,
    output logic [1:0]  o_lane
);

    localparam int LANE_W = IMG_W / NUM_LANES;

    logic [R_W-1:0] w_r;
    logic [G_W-1:0] w_g;
    logic [B_W-1:0] w_b;
    logic           w_is_red;
    logic           w_in_roi;

    assign w_r = i_pix_data[R_LSB +: R_W];
    assign w_g = i_pix_data[G_LSB +: G_W];
    assign w_b = i_pix_data[B_LSB +: B_W];

    assign w_is_red = (w_r >= R_W'(R_MIN)) && (w_g <= G_W'(G_MAX)) && (w_b <= B_W'(B_MAX));
    assign w_in_roi = (i_pix_y >= 10'(ROI_Y0)) && (i_pix_y <= 10'(ROI_Y1)) && (i_pix_x < 10'(IMG_W));
    assign o_qualify = w_is_red && w_in_roi;

    // Lane index = number of lane boundaries at or left of the column.
    always_comb begin
        o_lane = '0;
        for (int i = 1; i < NUM_LANES; i++) begin
            if (i_pix_x >= 10'(i * LANE_W)) begin
                o_lane = 2'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/lane_color_stats.sv
`default_nettype none
// ============================================================================
// Module   : lane_color_stats
// Brief    : Per-frame red-pixel counts per vertical lane, plus dominant lane.
// Revision : 1.0  initial release
// ============================================================================
module lane_color_stats
    import lane_stats_pkg::*;
#(
    parameter int IMG_W     = 320,
    parameter int IMG_H     = 240,
    parameter int NUM_LANES = 4,
    parameter int ROI_Y0    = 120,
    parameter int ROI_Y1    = 239,
    parameter int R_MIN     = 20,
    parameter int G_MAX     = 24,
    parameter int B_MAX     = 12,
    parameter int MIN_COUNT = 64,
    parameter int CNT_W     = 15
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       pix_valid,
    input  logic [9:0]                 pix_x,
    input  logic [9:0]                 pix_y,
    input  logic [15:0]                pix_data,
    input  logic                       frame_end,
    output logic [NUM_LANES*CNT_W-1:0] lane_count,
    output logic [1:0]                 dominant_lane,
    output logic                       dominant_valid,
    output logic                       result_valid,
    output logic [7:0]                 frame_cnt
);

    state_t             r_state;
    state_t             w_state_next;
    logic               w_qualify;
    logic [1:0]         w_lane;
    logic               r_s1_valid;
    logic [1:0]         r_s1_lane;
    logic [CNT_W-1:0]   r_acc [NUM_LANES];
    logic               w_clear;
    logic [1:0]         w_best_idx;
    logic [CNT_W-1:0]   w_best_cnt;

    logic [NUM_LANES*CNT_W-1:0] r_lane_count;
    logic [1:0]                 r_dominant_lane;
    logic                       r_dominant_valid;
    logic                       r_result_valid;
    logic [7:0]                 r_frame_cnt;

    rgb565_red_classifier #(
        .IMG_W     (IMG_W),
        .NUM_LANES (NUM_LANES),
        .ROI_Y0    (ROI_Y0),
        .ROI_Y1    (ROI_Y1),
        .R_MIN     (R_MIN),
        .G_MAX     (G_MAX),
        .B_MAX     (B_MAX)
    ) u_classifier (
        .i_pix_x    (pix_x),
        .i_pix_y    (pix_y),
        .i_pix_data (pix_data),
        .o_qualify  (w_qualify),
        .o_lane     (w_lane)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= SYNC;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            SYNC:    if (frame_end) w_state_next = ACCUM;
            ACCUM:   if (frame_end) w_state_next = FLUSH;
            FLUSH:   w_state_next = PUBLISH;
            PUBLISH: w_state_next = ACCUM;
            default: w_state_next = SYNC;
        endcase
    end

    // Stage 1: only pixels seen while accumulating enter the pipeline.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_lane  <= '0;
        end else begin
            r_s1_valid <= (r_state == ACCUM) && pix_valid && w_qualify;
            r_s1_lane  <= w_lane;
        end
    end

    // Clearing never coincides with a live stage-1 entry, so no pixel is lost.
    assign w_clear = ((r_state == SYNC) && frame_end) || (r_state == PUBLISH);

    always_ff @(posedge clk) begin
        if (reset || w_clear) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                r_acc[i] <= '0;
            end
        end else if (r_s1_valid && (r_acc[r_s1_lane] != {CNT_W{1'b1}})) begin
            r_acc[r_s1_lane] <= r_acc[r_s1_lane] + 1'b1;
        end
    end

    // Strict greater-than keeps ties on the lowest lane index.
    always_comb begin
        w_best_idx = '0;
        w_best_cnt = r_acc[0];
        for (int i = 1; i < NUM_LANES; i++) begin
            if (r_acc[i] > w_best_cnt) begin
                w_best_idx = 2'(i);
                w_best_cnt = r_acc[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lane_count     <= '0;
            r_dominant_lane  <= '0;
            r_dominant_valid <= 1'b0;
            r_result_valid   <= 1'b0;
            r_frame_cnt      <= '0;
        end else begin
            r_result_valid <= 1'b0;
            if (r_state == PUBLISH) begin
                for (int i = 0; i < NUM_LANES; i++) begin
                    r_lane_count[i*CNT_W +: CNT_W] <= r_acc[i];
                end
                r_dominant_lane  <= w_best_idx;
                r_dominant_valid <= (w_best_cnt >= CNT_W'(MIN_COUNT));
                r_result_valid   <= 1'b1;
                r_frame_cnt      <= r_frame_cnt + 8'd1;
            end
        end
    end

    assign lane_count     = r_lane_count;
    assign dominant_lane  = r_dominant_lane;
    assign dominant_valid = r_dominant_valid;
    assign result_valid   = r_result_valid;
    assign frame_cnt      = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_lane_color_stats.sv
`default_nettype none
// ============================================================================
// Module   : tb_lane_color_stats
// Brief    : Randomized self-checking bench with a per-frame counting model.
// Revision : 1.0  initial release
// ============================================================================
module tb_lane_color_stats;

    localparam int CNT_W = 15;

    logic        clk;
    logic        reset;
    logic        pix_valid;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic [15:0] pix_data;
    logic        frame_end;
    logic [59:0] lane_count;
    logic [1:0]  dominant_lane;
    logic        dominant_valid;
    logic        result_valid;
    logic [7:0]  frame_cnt;

    lane_color_stats u_dut (
        .clk            (clk),
        .reset          (reset),
        .pix_valid      (pix_valid),
        .pix_x          (pix_x),
        .pix_y          (pix_y),
        .pix_data       (pix_data),
        .frame_end      (frame_end),
        .lane_count     (lane_count),
        .dominant_lane  (dominant_lane),
        .dominant_valid (dominant_valid),
        .result_valid   (result_valid),
        .frame_cnt      (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit v;
        int x;
        int y;
        int d;
    } pix_t;

    pix_t        q_pix[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    bit          synced  = 0;
    int          exp_acc[4];
    logic [63:0] exp_lc  = '0;
    int          exp_dom = 0;
    int          exp_dv  = 0;
    int          exp_fc  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int x, input int y, input int d);
        pix_t p;
        p.v = 1'b1; p.x = x; p.y = y; p.d = d;
        q_pix.push_back(p);
    endtask

    task automatic push_rand(input int n);
        pix_t p;
        for (int i = 0; i < n; i++) begin
            p.v = ($urandom_range(0, 9) < 8);
            p.x = $urandom_range(0, 335);
            p.y = $urandom_range(100, 245);
            p.d = ($urandom_range(15, 31) << 11) | ($urandom_range(0, 30) << 5) | $urandom_range(0, 16);
            q_pix.push_back(p);
        end
    endtask

    function automatic bit counted(input pix_t p);
        int r = (p.d / 2048) % 32;
        int g = (p.d / 32) % 64;
        int b = p.d % 32;
        return p.v && p.y >= 120 && p.y <= 239 && p.x < 320 && r >= 20 && g <= 24 && b <= 12;
    endfunction

    task automatic publish_model();
        int mx = 0;
        exp_dom = -1;
        foreach (exp_acc[i]) if (exp_acc[i] > mx) mx = exp_acc[i];
        foreach (exp_acc[i]) if (exp_dom < 0 && exp_acc[i] == mx) exp_dom = i;
        exp_lc = '0;
        foreach (exp_acc[i]) exp_lc = exp_lc | (64'(exp_acc[i]) << (CNT_W * i));
        exp_dv = (mx >= 64) ? 1 : 0;
        exp_fc = (exp_fc + 1) % 256;
    endtask

    task automatic drive_pix(input pix_t p, input bit fe);
        pix_valid = p.v;
        pix_x     = 10'(p.x);
        pix_y     = 10'(p.y);
        pix_data  = 16'(p.d);
        frame_end = fe;
    endtask

    task automatic idle();
        pix_valid = 1'b0;
        frame_end = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_lane_count"}, 64'(lane_count), exp_lc);
        check({tag, "_dom_lane"}, 64'(dominant_lane), 64'(exp_dom));
        check({tag, "_dom_valid"}, 64'(dominant_valid), 64'(exp_dv));
        check({tag, "_frame_cnt"}, 64'(frame_cnt), 64'(exp_fc));
    endtask

    // Plays the queued pixels; the final one carries frame_end.
    task automatic play_frame(input string tag);
        bit   live = synced;
        pix_t g;
        foreach (exp_acc[i]) exp_acc[i] = 0;
        if (q_pix.size() == 0) begin
            idle();
            frame_end = 1'b1;
            step();
        end else begin
            foreach (q_pix[i]) begin
                drive_pix(q_pix[i], (i == q_pix.size() - 1));
                if (live && counted(q_pix[i])) begin
                    exp_acc[q_pix[i].x / 80] = (exp_acc[q_pix[i].x / 80] < 32767) ? exp_acc[q_pix[i].x / 80] + 1 : 32767;
                end
                step();
            end
        end
        g.v = 1'b1; g.x = $urandom_range(0, 319); g.y = 200; g.d = 16'hF800;
        if (live) drive_pix(g, 1'b1); else idle();
        step();
        check({tag, "_rv_flush"}, 64'(result_valid), 64'd0);
        if (live) drive_pix(g, 1'($urandom_range(0, 1))); else idle();
        step();
        if (live) publish_model();
        check({tag, "_rv_pub"}, 64'(result_valid), 64'(live));
        check_outputs(tag);
        idle();
        step();
        check({tag, "_rv_after"}, 64'(result_valid), 64'd0);
        synced = 1'b1;
        q_pix.delete();
    endtask

    task automatic do_reset(input string tag);
        pix_t g;
        g.v = 1'b1; g.x = 100; g.y = 150; g.d = 16'hF800;
        drive_pix(g, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        idle();
        synced = 1'b0;
        exp_lc = '0; exp_dom = 0; exp_dv = 0; exp_fc = 0;
        check({tag, "_rv"}, 64'(result_valid), 64'd0);
        check_outputs(tag);
    endtask

    initial begin
        reset = 1'b1;
        idle();
        pix_x = '0; pix_y = '0; pix_data = '0;
        step();
        step();
        do_reset("reset");

        push_rand(200);
        play_frame("sync");

        for (int x = 80; x < 160; x++)
            for (int y = 120; y < 240; y++)
                push(x, y, 16'hF800);
        play_frame("full");
        check("full_lane1", 64'(lane_count), 64'(9600) << CNT_W);
        check("full_dom", 64'(dominant_lane), 64'd1);

        push(5, 130, 19 << 11);
        push(6, 130, 20 << 11);
        push(90, 130, (31 << 11) | (24 << 5));
        push(91, 130, (31 << 11) | (25 << 5));
        push(170, 130, (31 << 11) | 12);
        push(171, 130, (31 << 11) | 13);
        push(250, 119, 16'hF800);
        push(251, 120, 16'hF800);
        push(79, 200, 16'hF800);
        push(80, 200, 16'hF800);
        push(320, 200, 16'hF800);
        play_frame("edges");

        for (int i = 0; i < 100; i++) begin
            push(170, 150, 16'hF800);
            push(250, 150, 16'hF800);
        end
        play_frame("tie");
        check("tie_dom2", 64'(dominant_lane), 64'd2);

        for (int i = 0; i < 63; i++)
            for (int l = 0; l < 4; l++)
                push(l * 80 + 7, 180, 16'hF800);
        play_frame("thresh");
        check("thresh_dv0", 64'(dominant_valid), 64'd0);

        push(300, 239, 16'hF800);
        play_frame("lastpix");

        for (int f = 0; f < 12; f++) begin
            push_rand($urandom_range(500, 900));
            play_frame("rand");
        end

        push_rand(30);
        foreach (q_pix[i]) begin
            drive_pix(q_pix[i], 1'b0);
            step();
        end
        q_pix.delete();
        do_reset("midreset");
        push_rand(100);
        play_frame("resync");
        push_rand(600);
        play_frame("post_reset");

        for (int f = 0; f < 255; f++) begin
            play_frame("wrap");
        end
        check("wrap_zero", 64'(frame_cnt), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
